// File: rtl/mpc_sequencer_pkg.sv
// Shared mixed-precision controller definitions: opcodes, vector formats,
// EX operand-mux selects and the sub-cycle ratio helper.
package mpc_sequencer_pkg;

    localparam logic [6:0]  OPCODE_VECOP  = 7'h57;
    localparam logic [6:0]  OPCODE_SYSTEM = 7'h73;

    localparam int unsigned NBITS_MAX_KER = 8;
    localparam int unsigned MPC_CTX_NUM   = 2;
    localparam int unsigned MPC_RATIO_W   = 4;
    localparam int unsigned MPC_NUM_DOTP  = 6;

    // DOTUP, DOTUSP, DOTSP, SDOTUP, SDOTUSP, SDOTSP
    localparam logic [MPC_NUM_DOTP-1:0][5:0] MPC_DOTP_FUNCT6 = {
        6'b101110, 6'b101010, 6'b101000,
        6'b100110, 6'b100010, 6'b100000
    };

    typedef enum logic [3:0] {
        IVEC_FMT_16,
        IVEC_FMT_8,
        IVEC_FMT_4,
        IVEC_FMT_2,
        MIXED_2x4,
        MIXED_4x8,
        MIXED_8x16,
        MIXED_2x8,
        MIXED_4x16,
        MIXED_2x16
    } ivec_mode_fmt;

    typedef enum logic [1:0] {
        MPC_CSR,
        MPC_CSR_WRITE,
        MPC_MIX_CNTRL
    } mux_sel_mpc;

    function automatic logic [MPC_RATIO_W-1:0] mpc_ratio(input ivec_mode_fmt fmt);
        case (fmt)
            MIXED_2x4, MIXED_4x8, MIXED_8x16: mpc_ratio = MPC_RATIO_W'(2);
            MIXED_2x8, MIXED_4x16:            mpc_ratio = MPC_RATIO_W'(4);
            MIXED_2x16:                       mpc_ratio = MPC_RATIO_W'(8);
            default:                          mpc_ratio = MPC_RATIO_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/mpc_sequencer_ctx_counter.sv
// One accumulation context: skip counter gating a modulo-ratio sub-cycle counter.
module mpc_ctx_counter
    import mpc_sequencer_pkg::*;
#(
    parameter int unsigned NBITS_CYC  = 3,
    parameter int unsigned NBITS_SKIP = NBITS_MAX_KER
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   load,
    input  logic [NBITS_CYC-1:0]   load_val,
    input  logic                   step,
    input  logic [NBITS_SKIP:0]    skip_eff,
    input  logic [MPC_RATIO_W-1:0] ratio,
    output logic [NBITS_CYC-1:0]   cycle,
    output logic [NBITS_CYC-1:0]   next_cycle,
    output logic                   cyc_step,
    output logic                   wrap,
    output logic                   busy
);

    localparam int unsigned CMP_W = (NBITS_CYC > MPC_RATIO_W) ? NBITS_CYC : MPC_RATIO_W;

    logic [NBITS_CYC-1:0]  cycle_q;
    logic [NBITS_SKIP-1:0] skip_q;
    logic [NBITS_SKIP:0]   skip_inc;
    logic                  skip_done;
    logic                  at_last;

    always_comb begin
        skip_inc  = {1'b0, skip_q} + (NBITS_SKIP+1)'(1);
        skip_done = !(skip_inc < skip_eff);
        cyc_step  = step && skip_done && (ratio > MPC_RATIO_W'(1));
        // >= rather than == so out-of-range CSR writes still wrap on the next step
        at_last   = CMP_W'(cycle_q) >= CMP_W'(ratio - MPC_RATIO_W'(1));
        next_cycle = cycle_q;
        if (cyc_step)
            next_cycle = at_last ? '0 : cycle_q + NBITS_CYC'(1);
        wrap = cyc_step && at_last && (cycle_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            skip_q  <= '0;
        end else if (clear) begin
            cycle_q <= '0;
            skip_q  <= '0;
        end else if (load) begin
            cycle_q <= load_val;
            skip_q  <= '0;
        end else if (step) begin
            if (skip_done) begin
                skip_q  <= '0;
                cycle_q <= next_cycle;
            end else begin
                skip_q  <= skip_inc[NBITS_SKIP-1:0];
            end
        end
    end

    assign cycle = cycle_q;
    assign busy  = (cycle_q != '0) || (skip_q != '0);

endmodule

// File: rtl/mpc_sequencer.sv
// Multi-context mixed-precision cycle controller: dotp/CSR decode, per-context
// counters, selected-context readout and the registered EX operand-mux select.
module mpc_sequencer
    import mpc_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CTX    = MPC_CTX_NUM,
    parameter int unsigned NBITS_CYC  = 3,
    parameter int unsigned NBITS_SKIP = NBITS_MAX_KER,
    parameter logic [11:0] CSR_ADDR   = 12'h00D,
    localparam int unsigned CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 illegal_insn_i,
    input  logic                 is_decoding_i,
    input  logic                 ex_ready_i,
    input  logic [31:0]          instr_rdata_i,
    input  ivec_mode_fmt         ivec_fmt_i,
    input  logic [CTX_W-1:0]     ctx_sel_i,
    input  logic [NBITS_SKIP-1:0] skip_size_i,
    input  logic                 csr_we_i,
    input  logic [NBITS_CYC-1:0] csr_wdata_i,
    input  logic                 flush_i,
    output logic [NBITS_CYC-1:0] cycle_o,
    output logic [NBITS_CYC-1:0] next_cycle_o,
    output logic                 mux_sel_wcsr_o,
    output mux_sel_mpc           mux_sel_mpc_o,
    output logic                 wrap_o,
    output logic [NUM_CTX-1:0]   busy_o
);

    logic                   is_dotp;
    logic                   is_csrw;
    logic                   fire;
    logic [NBITS_SKIP:0]    skip_eff;
    logic [MPC_RATIO_W-1:0] ratio;
    logic                   wrap_sel;
    logic                   unused_instr;

    logic [NBITS_CYC-1:0] cycle_a      [NUM_CTX];
    logic [NBITS_CYC-1:0] next_cycle_a [NUM_CTX];
    logic                 cyc_step_a   [NUM_CTX];
    logic                 wrap_a       [NUM_CTX];

    assign unused_instr = ^{instr_rdata_i[19:14], instr_rdata_i[11:7]};
    assign ratio        = mpc_ratio(ivec_fmt_i);

    always_comb begin
        is_dotp = 1'b0;
        if (instr_rdata_i[6:0] == OPCODE_VECOP) begin
            for (int unsigned i = 0; i < MPC_NUM_DOTP; i++)
                if (instr_rdata_i[31:26] == MPC_DOTP_FUNCT6[i])
                    is_dotp = 1'b1;
        end
        is_csrw  = (instr_rdata_i[6:0] == OPCODE_SYSTEM) &&
                   (instr_rdata_i[13:12] == 2'b01) &&
                   (instr_rdata_i[31:20] == CSR_ADDR);
        fire     = !illegal_insn_i && is_decoding_i && ex_ready_i && is_dotp;
        skip_eff = (skip_size_i == '0) ? (NBITS_SKIP+1)'(1) : {1'b0, skip_size_i};
    end

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
        logic sel;
        assign sel = (ctx_sel_i == CTX_W'(g));

        mpc_ctx_counter #(
            .NBITS_CYC  (NBITS_CYC),
            .NBITS_SKIP (NBITS_SKIP)
        ) u_ctx (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (flush_i),
            .load       (csr_we_i && sel),
            .load_val   (csr_wdata_i),
            .step       (fire && sel),
            .skip_eff   (skip_eff),
            .ratio      (ratio),
            .cycle      (cycle_a[g]),
            .next_cycle (next_cycle_a[g]),
            .cyc_step   (cyc_step_a[g]),
            .wrap       (wrap_a[g]),
            .busy       (busy_o[g])
        );
    end

    always_comb begin
        cycle_o        = '0;
        next_cycle_o   = '0;
        mux_sel_wcsr_o = 1'b0;
        wrap_sel       = 1'b0;
        for (int unsigned i = 0; i < NUM_CTX; i++) begin
            if (ctx_sel_i == CTX_W'(i)) begin
                cycle_o        = cycle_a[i];
                next_cycle_o   = next_cycle_a[i];
                mux_sel_wcsr_o = cyc_step_a[i];
                wrap_sel       = wrap_a[i];
            end
        end
    end

    // A wrap only counts if the step actually commits (no flush / CSR override)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_sel_mpc_o <= MPC_CSR;
            wrap_o        <= 1'b0;
        end else begin
            wrap_o <= wrap_sel && !flush_i && !csr_we_i;
            if (is_decoding_i) begin
                if (is_csrw)
                    mux_sel_mpc_o <= MPC_CSR_WRITE;
                else if (is_dotp)
                    mux_sel_mpc_o <= MPC_MIX_CNTRL;
                else
                    mux_sel_mpc_o <= MPC_CSR;
            end
        end
    end

endmodule
